// File: rtl/multi_debouncer.sv
// N-channel push-button/switch debouncer: per-channel 2-flop synchroniser,
// tick-gated stability counter, clean level plus registered rise/fall pulses.

module multi_debouncer_lane #(
  parameter int   CNT_W        = 15,
  parameter int   STABLE_TICKS = 32767,
  parameter logic RESET_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic sig_in,
  output logic sig_out,
  output logic rise,
  output logic fall,
  output logic busy
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_TICKS - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] cnt;
  logic             mismatch, accept;

  assign mismatch = s2 ^ sig_out;
  assign accept   = mismatch & tick & (cnt == LAST);
  assign busy     = (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= RESET_LEVEL;
      s2      <= RESET_LEVEL;
      sig_out <= RESET_LEVEL;
      cnt     <= '0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      s1   <= sig_in;
      s2   <= s1;
      rise <= accept & s2;
      fall <= accept & ~s2;
      if (accept) sig_out <= s2;
      // Any return to the current level restarts the window, tick or not.
      if (!mismatch || accept) cnt <= '0;
      else if (tick)           cnt <= cnt + 1'b1;
    end
  end
endmodule

module multi_debouncer #(
  parameter int   CHANNELS     = 4,
  parameter int   CNT_W        = 15,
  parameter int   STABLE_TICKS = 32767,
  parameter logic RESET_LEVEL  = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [CHANNELS-1:0] sig_in,
  output logic [CHANNELS-1:0] sig_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                busy
);
  logic [CHANNELS-1:0] ch_busy;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    multi_debouncer_lane #(
      .CNT_W       (CNT_W),
      .STABLE_TICKS(STABLE_TICKS),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .sig_in (sig_in[i]),
      .sig_out(sig_out[i]),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .busy   (ch_busy[i])
    );
  end

  assign busy = |ch_busy;
endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboarded bench: a cycle-level reference model pushes expected outputs,
// a negedge monitor pops and compares them against the DUT.

module tb_multi_debouncer;
  localparam int   CH = 4;
  localparam int   CW = 4;
  localparam int   ST = 4;
  localparam logic RL = 1'b0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b1;
  logic [CH-1:0] sig_in = '0;
  logic [CH-1:0] sig_out, rise, fall;
  logic          busy;

  int total = 0;
  int bad   = 0;

  multi_debouncer #(.CHANNELS(CH), .CNT_W(CW), .STABLE_TICKS(ST), .RESET_LEVEL(RL)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .sig_in(sig_in),
    .sig_out(sig_out), .rise(rise), .fall(fall), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] so;
    logic [CH-1:0] ri;
    logic [CH-1:0] fa;
    logic          bz;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Reference model: the raw input reaches the "seen" level two edges later;
  // a channel accepts after ST tick-cycles of uninterrupted disagreement.
  logic [CH-1:0] hist1, hist2, m_out;
  int            run[CH];

  always @(posedge clk) begin
    exp_t e;
    e.ri = '0;
    e.fa = '0;
    if (!rst_n) begin
      hist1 = {CH{RL}};
      hist2 = {CH{RL}};
      m_out = {CH{RL}};
      for (int i = 0; i < CH; i++) run[i] = 0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (hist2[i] == m_out[i]) run[i] = 0;
        else if (tick) begin
          run[i] = run[i] + 1;
          if (run[i] == ST) begin
            m_out[i] = hist2[i];
            run[i]   = 0;
            if (hist2[i]) e.ri[i] = 1'b1;
            else          e.fa[i] = 1'b1;
          end
        end
      end
      hist2 = hist1;
      hist1 = sig_in;
    end
    e.so = m_out;
    e.bz = 1'b0;
    for (int i = 0; i < CH; i++) if (run[i] != 0) e.bz = 1'b1;
    q.push_back(e);
  end

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("sig_out", sig_out, e.so);
      chk("rise", rise, e.ri);
      chk("fall", fall, e.fa);
      chk("busy", {{(CH-1){1'b0}}, busy}, {{(CH-1){1'b0}}, e.bz});
      chk("pulse_excl", rise & fall, '0);
    end
  end

  int n_rise, n_fall, n_both;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance n cycles while counting pulses on channel ch.
  task automatic count_pulses(input int ch, input int n, input logic gate8);
    n_rise = 0; n_fall = 0;
    for (int c = 0; c < n; c++) begin
      if (gate8) tick = (c % 8 == 0);
      @(negedge clk);
      if (rise[ch]) n_rise++;
      if (fall[ch]) n_fall++;
    end
  endtask

  initial begin
    // Reset and idle
    cyc(3);
    rst_n = 1'b1;
    cyc(20);
    chk("idle_out", sig_out, '0);

    // Clean press on ch0
    sig_in[0] = 1'b1;
    count_pulses(0, 12, 1'b0);
    chk("press_rise_cnt", CH'(n_rise), CH'(1));
    chk("press_level", sig_out, 4'b0001);

    // Bounce on ch1, then hold high
    foreach (sig_in[i]) if (i == 99) sig_in[i] = 1'b0;
    for (int b = 0; b < 4; b++) begin
      sig_in[1] = ~b[0];
      count_pulses(1, 2, 1'b0);
      chk("bounce_no_rise", CH'(n_rise), '0);
    end
    sig_in[1] = 1'b1;
    count_pulses(1, 14, 1'b0);
    chk("bounce_rise_cnt", CH'(n_rise), CH'(1));
    chk("bounce_fall_cnt", CH'(n_fall), '0);

    // Tick gating: ch2 high first, then a clean fall with 1-in-8 ticks
    sig_in[2] = 1'b1;
    cyc(10);
    sig_in[2] = 1'b0;
    count_pulses(2, 60, 1'b1);
    chk("gated_fall_cnt", CH'(n_fall), CH'(1));
    chk("gated_rise_cnt", CH'(n_rise), '0);
    tick = 1'b1;

    // Simultaneous press on ch0 and ch3
    sig_in[0] = 1'b0;
    cyc(12);
    sig_in[0] = 1'b1; sig_in[3] = 1'b1;
    n_both = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rise == 4'b1001) n_both++;
    end
    chk("simul_rise", CH'(n_both), CH'(1));

    // Reset while ch0 counter sits at 2
    sig_in[0] = 1'b0;
    cyc(4);
    rst_n = 1'b0;
    #1;
    chk("rst_async_out", sig_out, '0);
    chk("rst_async_pulse", rise | fall, '0);
    cyc(2);
    rst_n = 1'b1;
    sig_in = 4'b0001;
    cyc(15);

    // Randomised phase
    for (int c = 0; c < 3000; c++) begin
      tick = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) == 0) sig_in[$urandom_range(0, CH-1)] ^= 1'b1;
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
      end
      cyc(1);
    end
    cyc(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
Parametrised N-channel debouncer for raw push-button and switch inputs. Each channel has a 2-flop synchroniser, its own stability counter, and a clean level output with one-cycle rise and fall pulses. A tick input gates counting, so one fast system clock can drive slow debounce windows without a derived clock. It sits between board pins and the control FSMs, and it replaces the single-channel debouncer with its software-style reset.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
CNT_W, 15, width of each per-channel counter
STABLE_TICKS, 32767, consecutive qualifying ticks of disagreement needed to accept a new level; 1 <= STABLE_TICKS <= 2^CNT_W-1
RESET_LEVEL, 1'b0, value loaded into the synchronisers and the clean output at reset

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
tick  in  1  count enable; counters advance only on cycles with tick=1
sig_in  in  CHANNELS  raw asynchronous inputs, bit i = channel i
sig_out  out  CHANNELS  debounced level per channel
rise  out  CHANNELS  one-cycle pulse when sig_out[i] goes 0->1
fall  out  CHANNELS  one-cycle pulse when sig_out[i] goes 1->0
busy  out  1  high while any channel counter is non-zero

Behaviour:
- Reset (rst_n=0, async assert, sync release by the upstream reset bridge):
  - sync stages = RESET_LEVEL; sig_out = RESET_LEVEL.
  - all counters = 0; rise = fall = 0; busy = 0.
- Synchroniser: s1[i] <= sig_in[i]; s2[i] <= s1[i]. Only s2 is used downstream.
- Per channel, evaluated every clk edge, with mismatch = (s2[i] != sig_out[i]):
  - mismatch=0: counter <= 0, regardless of tick. This is the glitch rejection: any return to the current level restarts the window.
  - mismatch=1, tick=0: counter holds.
  - mismatch=1, tick=1, counter < STABLE_TICKS-1: counter <= counter+1.
  - mismatch=1, tick=1, counter == STABLE_TICKS-1: sig_out[i] <= s2[i]; counter <= 0; rise[i] or fall[i] <= 1 for exactly one cycle, according to the new level.
- Pulses:
  - rise and fall are registered and are never both high on one channel.
  - They are 0 on every cycle without an accept event.
- Latency, with tick tied high: a raw change sampled at edge k gives s2 at edge k+1. sig_out changes at edge k+1+STABLE_TICKS, and the pulse is visible for the following cycle.
- Channels are fully independent. Simultaneous accepts on several channels produce simultaneous pulses.
- Counter never wraps, because the accept condition clears it at STABLE_TICKS-1.
- STABLE_TICKS=1: a level is accepted on the first qualifying tick after s2 disagrees.
- busy = OR over all channels of (counter != 0), combinational from the registers.
- Reset mid-count: the counter and outputs return immediately to their reset values. No pulse is generated by reset itself.
- No latches. All storage is in clocked always blocks with async reset on negedge rst_n.

Test Plan:
1. Reset: CHANNELS=4, STABLE_TICKS=4, tick=1, sig_in=4'b0000, release rst_n. Required: sig_out=0, rise=fall=0, busy=0 for 20 cycles.
2. Clean press: raise sig_in[0] before edge 1. Required: sig_out[0]=1 after edge 6; rise[0]=1 for exactly the cycle after edge 6; other channels unchanged.
3. Bounce: on sig_in[1], toggle 1,0,1,0 with 2-cycle periods, then hold 1. Required: no change on sig_out[1] until 4 qualifying ticks after the final stable sample; exactly one rise[1] pulse; no fall[1].
4. Tick gating: set tick high 1 cycle in 8 and drive a clean 1->0 on channel 2, previously stable high. Required: sig_out[2] falls only after the 4th tick following the synchronised change; fall[2] is a single pulse; busy stays high in between.
5. Simultaneous accepts: press channels 0 and 3 on the same cycle. Required: rise=4'b1001 in one cycle.
6. Reset mid-count: assert rst_n=0 while counter[0]=2. Required: outputs return to RESET_LEVEL, busy=0, no pulse; a fresh full window is needed after release.
